mux_scan_sequencer: RTL and testbench

//  Upstream driver for the 16:1 bit mux: steps `sel` through every channel and waits a settle time.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_outreg.sv | 52 +++++
 rtl/mux_scan_sequencer.sv | 114 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan sequencer.
// Holds the FSM state encoding and the dwell-counter width helper.
package mux_scan_pkg;

  typedef enum logic {IDLE, SCAN} scan_state_t;

  localparam int DEF_N_CH       = 16;
  localparam int DEF_SETTLE_CYC = 1;

  // A zero settle time still needs a 1-bit counter to keep the datapath legal
  function automatic int cnt_width(input int settle_cyc);
    return (settle_cyc < 1) ? 1 : $clog2(settle_cyc + 1);
  endfunction

endpackage

// File: rtl/mux_scan_outreg.sv
// Single-entry valid/ready output slot for assembled scan words; flags overrun on a full slot.
// Define SCAN_PARITY_EN to carry an even-parity bit (word_par) alongside the word.
module mux_scan_outreg #(
  parameter int N_CH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [N_CH-1:0] din,
  input  logic            ready,
  output logic [N_CH-1:0] word,
  output logic            word_valid,
  output logic            overrun
`ifdef SCAN_PARITY_EN
  ,
  output logic            word_par
`endif
);

  logic slot_free;

  assign slot_free = !word_valid || ready;

  // Accepting a word on the same edge the consumer drains the slot keeps valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SCAN_PARITY_EN
      word_par   <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (load && slot_free) begin
        word       <= din;
        word_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
        word_par   <= ^din;
`endif
      end else begin
        if (load) begin
          overrun <= 1'b1;
        end
        if (word_valid && ready) begin
          word_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Drives sel of a 16:1 bit mux through every channel, samples each after a settle dwell,
// and presents the assembled word on valid/ready. Define SCAN_PARITY_EN to add word_par.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int SEL_W      = $clog2(N_CH),
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun
`ifdef SCAN_PARITY_EN
  ,
  output logic             word_par
`endif
);

  localparam int               CNT_W    = cnt_width(SETTLE_CYC);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  scan_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [N_CH-2:0]  shadow, shadow_nx;
  logic             busy_nx;
  logic             scan_done;
  logic [N_CH-1:0]  load_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      shadow <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      cnt    <= cnt_nx;
      shadow <= shadow_nx;
      busy   <= busy_nx;
    end
  end

  // The last channel bypasses the shadow and goes straight into the output word
  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    cnt_nx    = cnt;
    shadow_nx = shadow;
    busy_nx   = busy;
    scan_done = 1'b0;
    case (state)
      IDLE: begin
        if (start || cont) begin
          state_nx = SCAN;
          sel_nx   = '0;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
        end
      end
      SCAN: begin
        if (int'(cnt) < SETTLE_CYC) begin
          cnt_nx = cnt + 1'b1;
        end else begin
          cnt_nx = '0;
          if (sel != LAST_SEL) begin
            shadow_nx[sel] = mux_out;
            sel_nx         = sel + 1'b1;
          end else begin
            scan_done = 1'b1;
            sel_nx    = '0;
            if (!cont) begin
              state_nx = IDLE;
              busy_nx  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign load_word = {mux_out, shadow};

  mux_scan_outreg #(
    .N_CH (N_CH)
  ) u_outreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (scan_done),
    .din        (load_word),
    .ready      (word_ready),
    .word       (word),
    .word_valid (word_valid),
    .overrun    (overrun)
`ifdef SCAN_PARITY_EN
    ,
    .word_par   (word_par)
`endif
  );

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer with a behavioural 16:1 mux model.
// Parity checks are compiled in when SCAN_PARITY_EN is defined.
module tb_mux_scan_sequencer;

  localparam int N_CH     = 16;
  localparam int SETTLE   = 1;
  localparam int DWELL    = SETTLE + 1;
  localparam int SCAN_CYC = N_CH * DWELL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic [15:0] mux_in;
  logic        mux_out;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;
`ifdef SCAN_PARITY_EN
  logic        word_par;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mux_out = mux_in[sel];

  mux_scan_sequencer #(
    .N_CH       (N_CH),
    .SEL_W      (4),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .mux_out    (mux_out),
    .sel        (sel),
    .busy       (busy),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun)
`ifdef SCAN_PARITY_EN
    ,
    .word_par   (word_par)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word a scan starting at edge s would build if mux_in switches from old to new after edge tc
  function automatic logic [15:0] expectedWord(input int s, input int tc,
                                               input logic [15:0] old_pat,
                                               input logic [15:0] new_pat);
    logic [15:0] w;
    for (int i = 0; i < N_CH; i++) begin
      w[i] = (s + (i + 1) * DWELL > tc) ? new_pat[i] : old_pat[i];
    end
    return w;
  endfunction

  // One-shot scan from idle with an empty slot; ign_at >= 0 pulses start mid-scan
  task automatic applyStimulus(input logic [15:0] pat, input logic rdy, input int ign_at);
    mux_in     = pat;
    word_ready = rdy;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n <= SCAN_CYC; n++) begin
      if (n > 0) tick();
      start = (n == ign_at);
      checkOutput("sel_step", 32'(sel), (n < SCAN_CYC) ? 32'(n / DWELL) : 32'd0);
      checkOutput("busy", 32'(busy), 32'(n < SCAN_CYC));
      checkOutput("valid_latency", 32'(word_valid), 32'(n == SCAN_CYC));
    end
    start = 1'b0;
    checkOutput("word", 32'(word), 32'(pat));
    if (rdy) begin
      tick();
      checkOutput("valid_clear", 32'(word_valid), 32'd0);
    end
  endtask

  initial begin
    int          hold;
    int          tc;
    logic [15:0] pat;
    logic [15:0] held;
    int          vcyc[$];
    logic [15:0] vword[$];

    rst_n      = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    word_ready = 1'b0;
    mux_in     = 16'h3f0a;

    $display("[TB] reset");
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_sel", 32'(sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_word", 32'(word), 32'd0);
    checkOutput("rst_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] one-shot");
    applyStimulus(16'h3f0a, 1'b1, -1);

    $display("[TB] backpressure");
    applyStimulus(16'h3f0a, 1'b0, -1);
    hold = $urandom_range(1, 6);
    for (int k = 0; k < hold; k++) begin
      tick();
      checkOutput("bp_valid_hold", 32'(word_valid), 32'd1);
      checkOutput("bp_word_hold", 32'(word), 32'h3f0a);
    end
    word_ready = 1'b1;
    tick();
    checkOutput("bp_valid_clear", 32'(word_valid), 32'd0);

    $display("[TB] random one-shots");
    for (int k = 0; k < 4; k++) begin
      pat = 16'($urandom);
      applyStimulus(pat, 1'b1, -1);
    end

    $display("[TB] ignored start");
    applyStimulus(16'h3f0a, 1'b1, 10);

    $display("[TB] overrun");
    mux_in     = 16'h3f0a;
    word_ready = 1'b0;
    cont       = 1'b1;
    tick();
    checkOutput("ov_busy", 32'(busy), 32'd1);
    for (int n = 1; n <= 2 * SCAN_CYC; n++) begin
      tick();
      checkOutput("ov_pulse", 32'(overrun), 32'(n == 2 * SCAN_CYC));
      checkOutput("ov_valid", 32'(word_valid), 32'(n >= SCAN_CYC));
      if (n >= SCAN_CYC) checkOutput("ov_word", 32'(word), 32'h3f0a);
    end
    cont       = 1'b0;
    word_ready = 1'b1;
    for (int n = 2 * SCAN_CYC + 1; n <= 3 * SCAN_CYC + 1; n++) begin
      tick();
      checkOutput("ov_drain_valid", 32'(word_valid), 32'(n == 3 * SCAN_CYC));
      checkOutput("ov_drain_busy", 32'(busy), 32'(n < 3 * SCAN_CYC));
      checkOutput("ov_quiet", 32'(overrun), 32'd0);
    end

    $display("[TB] continuous");
    mux_in     = 16'h3f0a;
    word_ready = 1'b1;
    cont       = 1'b1;
    tc         = $urandom_range(SCAN_CYC + 2, 2 * SCAN_CYC - 2);
    tick();
    for (int n = 1; n <= 4 * SCAN_CYC; n++) begin
      tick();
      if (n == tc) mux_in = 16'hA5C3;
      if (n == 3 * SCAN_CYC + 4) cont = 1'b0;
      if (word_valid) begin
        vcyc.push_back(n);
        vword.push_back(word);
      end
    end
    checkOutput("cont_count", 32'(vcyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("cont_spacing", 32'(vcyc[k]), 32'((k + 1) * SCAN_CYC));
      checkOutput("cont_word", 32'(vword[k]),
                  32'(expectedWord(k * SCAN_CYC, tc, 16'h3f0a, 16'hA5C3)));
    end
    checkOutput("cont_stop", 32'(busy), 32'd0);
    tick();

`ifdef SCAN_PARITY_EN
    $display("[TB] parity");
    applyStimulus(16'h3f0a, 1'b0, -1);
    checkOutput("par_3f0a", 32'(word_par), 32'(^16'h3f0a));
    word_ready = 1'b1;
    tick();
    applyStimulus(16'h0001, 1'b0, -1);
    checkOutput("par_0001", 32'(word_par), 32'd1);
    word_ready = 1'b1;
    tick();
`endif

    $display("[TB] reset mid-scan");
    applyStimulus(16'hBEEF, 1'b0, -1);
    held       = word;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 14; n++) tick();
    checkOutput("mid_sel", 32'(sel), 32'd7);
    checkOutput("mid_word_before", 32'(word), 32'(16'hBEEF));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sel", 32'(sel), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_word", 32'(word), 32'd0);
    checkOutput("mid_rst_valid", 32'(word_valid), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < SCAN_CYC + 8; n++) begin
      tick();
      checkOutput("post_rst_valid", 32'(word_valid), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
    if (held != 16'hBEEF) $display("[TB] note: held word was %0h", held);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
